// File: rtl/alu_issue_stage.sv
// Execute-entry stage: decodes RV32I ALU-class instructions into operand/op form
// and presents them to the ALU through a registered 2-entry skid buffer.
`timescale 1ns/1ps
module alu_issue_stage #(
  parameter int XLEN = 32,
  parameter int RD_W = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [6:0]      in_opcode,
  input  logic [2:0]      in_funct3,
  input  logic            in_funct7_5,
  input  logic [XLEN-1:0] in_rs1_data,
  input  logic [XLEN-1:0] in_rs2_data,
  input  logic [XLEN-1:0] in_imm,
  input  logic [XLEN-1:0] in_pc,
  input  logic [RD_W-1:0] in_rd,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_a,
  output logic [XLEN-1:0] out_b,
  output logic [2:0]      out_operation,
  output logic [RD_W-1:0] out_rd,
  output logic            out_illegal
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_XOR = 3'b100
  } alu_op_e;

  typedef struct packed {
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    alu_op_e         op;
    logic [RD_W-1:0] rd;
    logic            illegal;
  } entry_t;

  entry_t dec;
  entry_t main_q;
  entry_t skid_q;
  logic   main_valid;
  logic   skid_valid;
  logic   in_xfer;
  logic   out_xfer;

  // Unsupported encodings leave operands and op at zero but still carry rd.
  always_comb begin
    dec         = '0;
    dec.rd      = in_rd;
    dec.illegal = 1'b1;
    case (in_opcode)
      OPC_OP, OPC_OP_IMM: begin
        dec.a       = in_rs1_data;
        dec.b       = (in_opcode == OPC_OP) ? in_rs2_data : in_imm;
        dec.illegal = 1'b0;
        case (in_funct3)
          3'b000:  dec.op = (in_opcode == OPC_OP && in_funct7_5) ? ALU_SUB : ALU_ADD;
          3'b100:  dec.op = ALU_XOR;
          3'b110:  dec.op = ALU_OR;
          3'b111:  dec.op = ALU_AND;
          default: begin
            dec.illegal = 1'b1;
            dec.a       = '0;
            dec.b       = '0;
          end
        endcase
      end
      OPC_LUI: begin
        dec.b       = in_imm;
        dec.illegal = 1'b0;
      end
      OPC_AUIPC: begin
        dec.a       = in_pc;
        dec.b       = in_imm;
        dec.illegal = 1'b0;
      end
      OPC_LOAD, OPC_STORE: begin
        dec.a       = in_rs1_data;
        dec.b       = in_imm;
        dec.illegal = 1'b0;
      end
      default: ;
    endcase
  end

  assign in_ready = !skid_valid;
  assign in_xfer  = in_valid && in_ready;
  assign out_xfer = main_valid && out_ready;

  // The skid entry is always older than new input, so it refills main first.
  always_ff @(posedge clk) begin
    if (rst) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      main_q     <= '0;
      skid_q     <= '0;
    end else if (flush) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else if (!main_valid) begin
      if (in_xfer) begin
        main_q     <= dec;
        main_valid <= 1'b1;
      end
    end else if (out_xfer) begin
      if (skid_valid) begin
        main_q     <= skid_q;
        skid_valid <= 1'b0;
      end else if (in_xfer) begin
        main_q <= dec;
      end else begin
        main_valid <= 1'b0;
      end
    end else if (in_xfer) begin
      skid_q     <= dec;
      skid_valid <= 1'b1;
    end
  end

  assign out_valid     = main_valid;
  assign out_a         = main_q.a;
  assign out_b         = main_q.b;
  assign out_operation = main_q.op;
  assign out_rd        = main_q.rd;
  assign out_illegal   = main_q.illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Scoreboard bench for alu_issue_stage: driver pushes expected entries on input
// transfer, a negedge monitor pops and compares on every output transfer.
`timescale 1ns/1ps
module tb_alu_issue_stage;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [6:0]  in_opcode = '0;
  logic [2:0]  in_funct3 = '0;
  logic        in_funct7_5 = 1'b0;
  logic [31:0] in_rs1_data = '0;
  logic [31:0] in_rs2_data = '0;
  logic [31:0] in_imm = '0;
  logic [31:0] in_pc = '0;
  logic [4:0]  in_rd = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_a;
  logic [31:0] out_b;
  logic [2:0]  out_operation;
  logic [4:0]  out_rd;
  logic        out_illegal;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  op;
    logic [4:0]  rd;
    logic        ill;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad = 0;
  int   pushes = 0;
  int   pops = 0;

  alu_issue_stage #(.XLEN(32), .RD_W(5)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_funct3(in_funct3), .in_funct7_5(in_funct7_5),
    .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data),
    .in_imm(in_imm), .in_pc(in_pc), .in_rd(in_rd),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_a(out_a), .out_b(out_b), .out_operation(out_operation),
    .out_rd(out_rd), .out_illegal(out_illegal)
  );

  always #5 clk = ~clk;

  // Reference decode written from the instruction-class table.
  function automatic exp_t model(input logic [6:0] opc, input logic [2:0] f3, input logic f75,
                                 input logic [31:0] rs1, input logic [31:0] rs2,
                                 input logic [31:0] imm, input logic [31:0] pc,
                                 input logic [4:0] rd);
    exp_t e;
    e.a = 0; e.b = 0; e.op = 3'd0; e.rd = rd; e.ill = 1'b1;
    if (opc == OPC_LUI) begin
      e.ill = 1'b0; e.b = imm;
    end else if (opc == OPC_AUIPC) begin
      e.ill = 1'b0; e.a = pc; e.b = imm;
    end else if (opc == OPC_LOAD || opc == OPC_STORE) begin
      e.ill = 1'b0; e.a = rs1; e.b = imm;
    end else if ((opc == OPC_OP || opc == OPC_OP_IMM) &&
                 (f3 == 3'd0 || f3 == 3'd4 || f3 == 3'd6 || f3 == 3'd7)) begin
      e.ill = 1'b0;
      e.a = rs1;
      e.b = (opc == OPC_OP) ? rs2 : imm;
      if (f3 == 3'd0)      e.op = (opc == OPC_OP && f75) ? 3'd1 : 3'd0;
      else if (f3 == 3'd4) e.op = 3'd4;
      else if (f3 == 3'd6) e.op = 3'd3;
      else                 e.op = 3'd2;
    end
    return e;
  endfunction

  task automatic checkOutput(input string name, input logic [79:0] act, input logic [79:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("[TB] FAIL %s: actual=%h required=%h at %0t", name, act, expv, $time);
    end
  endtask

  // One cycle of stimulus; expected entry is queued when the transfer will happen.
  task automatic applyStimulus(input logic v, input logic [6:0] opc, input logic [2:0] f3,
                               input logic f75, input logic [31:0] rs1, input logic [31:0] rs2,
                               input logic [31:0] imm, input logic [31:0] pc, input logic [4:0] rd,
                               input logic ordy, input logic fl, input logic rs);
    @(posedge clk);
    #1;
    in_valid = v; in_opcode = opc; in_funct3 = f3; in_funct7_5 = f75;
    in_rs1_data = rs1; in_rs2_data = rs2; in_imm = imm; in_pc = pc; in_rd = rd;
    out_ready = ordy; flush = fl; rst = rs;
    if (v && in_ready && !fl && !rs) begin
      q.push_back(model(opc, f3, f75, rs1, rs2, imm, pc, rd));
      pushes++;
    end
    @(negedge clk);
    #1;
    if (fl || rs) q.delete();
  endtask

  task automatic idle(input logic ordy);
    applyStimulus(1'b0, 7'd0, 3'd0, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 5'd0, ordy, 1'b0, 1'b0);
  endtask

  task automatic sendRandom(input logic v, input logic ordy, input logic fl);
    logic [6:0] opc;
    case ($urandom_range(0, 7))
      0: opc = OPC_OP;
      1: opc = OPC_OP_IMM;
      2: opc = OPC_LUI;
      3: opc = OPC_AUIPC;
      4: opc = OPC_LOAD;
      5: opc = OPC_STORE;
      6: opc = OPC_OP;
      default: opc = 7'($urandom);
    endcase
    applyStimulus(v, opc, 3'($urandom), 1'($urandom), $urandom, $urandom, $urandom, $urandom,
                  5'($urandom), ordy, fl, 1'b0);
  endtask

  // Monitor: compare on output transfer, and require stability while stalled.
  initial begin
    logic        held;
    logic [79:0] last;
    logic [79:0] cur;
    exp_t        e;
    held = 1'b0;
    last = '0;
    forever begin
      @(negedge clk);
      cur = {7'd0, out_a, out_b, out_operation, out_rd, out_illegal};
      if (!rst && out_valid) begin
        if (held) checkOutput("hold_stable", cur, last);
        if (out_ready) begin
          if (q.size() == 0) begin
            checkOutput("unexpected_output", {79'd0, out_valid}, 80'd0);
          end else begin
            e = q.pop_front();
            checkOutput("scoreboard", cur, {7'd0, e.a, e.b, e.op, e.rd, e.ill});
            pops++;
          end
        end
        held = !out_ready;
        last = cur;
      end else begin
        held = 1'b0;
      end
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int p0;
    int s0;
    applyStimulus(1'b0, 7'd0, 3'd0, 1'b0, 0, 0, 0, 0, 5'd0, 1'b0, 1'b0, 1'b1);
    idle(1'b0);
    checkOutput("rst_out_valid", {79'd0, out_valid}, 80'd0);
    checkOutput("rst_in_ready", {79'd0, in_ready}, 80'd1);
    checkOutput("rst_fields", {7'd0, out_a, out_b, out_operation, out_rd, out_illegal}, 80'd0);

    // OP sub, one-cycle latency
    applyStimulus(1'b1, OPC_OP, 3'd0, 1'b1, 32'd10, 32'd3, 32'd0, 32'd0, 5'd7, 1'b1, 1'b0, 1'b0);
    idle(1'b1);
    checkOutput("sub_valid", {79'd0, out_valid}, 80'd1);
    checkOutput("sub_fields", {7'd0, out_a, out_b, out_operation, out_rd, out_illegal},
                {7'd0, 32'd10, 32'd3, 3'd1, 5'd7, 1'b0});

    // AUIPC then LUI back to back
    applyStimulus(1'b1, OPC_AUIPC, 3'd0, 1'b0, 32'h55, 32'h66, 32'h2000, 32'h1000, 5'd1, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, OPC_LUI, 3'd0, 1'b0, 32'h55, 32'h66, 32'hABCDE000, 32'h1000, 5'd2, 1'b1, 1'b0, 1'b0);
    checkOutput("auipc_ab", {16'd0, out_a, out_b}, {16'd0, 32'h1000, 32'h2000});
    idle(1'b1);
    checkOutput("lui_ab", {16'd0, out_a, out_b}, {16'd0, 32'h0, 32'hABCDE000});

    // Backpressure: three instructions with out_ready low
    applyStimulus(1'b1, OPC_OP, 3'd0, 1'b0, 32'd1, 32'd100, 0, 0, 5'd1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, OPC_OP, 3'd0, 1'b0, 32'd2, 32'd200, 0, 0, 5'd2, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, OPC_OP, 3'd0, 1'b0, 32'd3, 32'd300, 0, 0, 5'd3, 1'b0, 1'b0, 1'b0);
    checkOutput("bp_in_ready_low", {79'd0, in_ready}, 80'd0);
    checkOutput("bp_head", {43'd0, out_a, out_rd}, {43'd0, 32'd1, 5'd1});
    applyStimulus(1'b1, OPC_OP, 3'd0, 1'b0, 32'd3, 32'd300, 0, 0, 5'd3, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, OPC_OP, 3'd0, 1'b0, 32'd3, 32'd300, 0, 0, 5'd3, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, OPC_OP, 3'd0, 1'b0, 32'd3, 32'd300, 0, 0, 5'd3, 1'b1, 1'b0, 1'b0);
    idle(1'b1);
    idle(1'b1);
    checkOutput("bp_drained", {48'd0, 32'(q.size())}, 80'd0);

    // Unsupported shift-immediate
    applyStimulus(1'b1, OPC_OP_IMM, 3'd1, 1'b0, 32'hDEAD, 32'hBEEF, 32'h5, 0, 5'd9, 1'b0, 1'b0, 1'b0);
    idle(1'b1);
    checkOutput("slli_illegal", {7'd0, out_a, out_b, out_operation, out_rd, out_illegal},
                {7'd0, 32'd0, 32'd0, 3'd0, 5'd9, 1'b1});
    idle(1'b1);

    // Flush with both entries full, then with an accepted input in flight
    sendRandom(1'b1, 1'b0, 1'b0);
    sendRandom(1'b1, 1'b0, 1'b0);
    sendRandom(1'b1, 1'b0, 1'b1);
    idle(1'b1);
    checkOutput("flush_full_valid", {79'd0, out_valid}, 80'd0);
    checkOutput("flush_full_ready", {79'd0, in_ready}, 80'd1);
    sendRandom(1'b1, 1'b0, 1'b0);
    sendRandom(1'b1, 1'b0, 1'b1);
    idle(1'b1);
    checkOutput("flush_input_dropped", {79'd0, out_valid}, 80'd0);
    idle(1'b1);
    idle(1'b1);

    // Reset mid-stream
    sendRandom(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 7'd0, 3'd0, 1'b0, 0, 0, 0, 0, 5'd0, 1'b0, 1'b0, 1'b1);
    idle(1'b1);
    checkOutput("midrst_state", {78'd0, out_valid, in_ready}, {78'd0, 1'b0, 1'b1});
    checkOutput("midrst_fields", {7'd0, out_a, out_b, out_operation, out_rd, out_illegal}, 80'd0);

    // Back-to-back stream of 50 with out_ready high
    p0 = pops;
    s0 = pushes;
    for (int i = 0; i < 50; i++) begin
      sendRandom(1'b1, 1'b1, 1'b0);
      if (i > 0) checkOutput("stream_out_valid", {79'd0, out_valid}, 80'd1);
    end
    idle(1'b1);
    idle(1'b1);
    checkOutput("stream_accepted", {48'd0, 32'(pushes - s0)}, 80'd50);
    checkOutput("stream_emitted", {48'd0, 32'(pops - p0)}, 80'd50);

    // Random traffic with backpressure and occasional flush
    for (int i = 0; i < 400; i++)
      sendRandom(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) != 0),
                 1'($urandom_range(0, 39) == 0));
    for (int i = 0; i < 10 && q.size() != 0; i++) idle(1'b1);
    idle(1'b1);
    checkOutput("final_queue_empty", {48'd0, 32'(q.size())}, 80'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
